// File: rtl/dm_pipe.sv
// Word-addressed data memory with a power-up clear sequence and a 1- or 2-stage read pipeline.
// Requests are taken only after every word has been zeroed; illegal requests raise a sticky err.
module dm_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic                re,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wrt_data,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_vld,
    output logic                err,
    input  logic                err_clr
);

    // state   | meaning
    // ST_INIT | zeroing mem one word per cycle, requests ignored
    // ST_RUN  | accepting requests
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_s1_vld;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_err;

    logic                w_rdy;
    logic                w_clr_en;
    logic                w_in_range;
    logic                w_acc;
    logic                w_wr;
    logic                w_rd;
    logic                w_err_set;
    logic [DATA_W-1:0]   w_rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_clr_ptr == LP_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_rdy    = 1'b0;
        w_clr_en = 1'b0;
        case (r_state)
            ST_INIT: w_clr_en = 1'b1;
            ST_RUN:  w_rdy    = 1'b1;
            default: begin
                w_rdy    = 1'b0;
                w_clr_en = 1'b0;
            end
        endcase
    end

    assign req_rdy = w_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_ptr <= '0;
        end else if (w_clr_en && (r_clr_ptr != LP_LAST)) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // rst gates acceptance so a request seen during the reset cycle never lands
    assign w_in_range = ({1'b0, addr} < LP_DEPTH);
    assign w_acc      = req_vld && w_rdy && !rst;
    assign w_wr       = w_acc && we && !re && w_in_range;
    assign w_rd       = w_acc && re && !we;
    assign w_err_set  = w_acc && ((re && we) || ((re || we) && !w_in_range));
    assign w_rd_word  = w_in_range ? r_mem[addr] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_en) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (byte_en[b]) r_mem[addr][8*b +: 8] <= wrt_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld  <= w_rd;
            r_s1_data <= w_rd ? w_rd_word : '0;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2_vld;
            logic [DATA_W-1:0] r_s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_vld  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_vld  <= r_s1_vld;
                    r_s2_data <= r_s1_data;
                end
            end

            assign rd_vld  = r_s2_vld;
            assign rd_data = r_s2_data;
        end else begin : g_lat1
            assign rd_vld  = r_s1_vld;
            assign rd_data = r_s1_data;
        end
    endgenerate

    // a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe built with DEPTH=1000 and RD_LAT=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_dm_pipe;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic              req_vld;
    logic              req_rdy;
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrt_data;
    logic [1:0]        byte_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld;
    logic              err;
    logic              err_clr;

    int n_cmp = 0;
    int n_mis = 0;

    dm_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .re       (re),
        .we       (we),
        .addr     (addr),
        .wrt_data (wrt_data),
        .byte_en  (byte_en),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-cycle request, entered and left on a falling edge
    task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [1:0] be);
        req_vld  = 1'b1;
        re       = r;
        we       = w;
        addr     = a;
        wrt_data = d;
        byte_en  = be;
        @(negedge clk);
        req_vld  = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
    endtask

    // returns the response seen two cycles after the accept edge
    task automatic read_word(input logic [ADDR_W-1:0] a, output logic v, output logic [DATA_W-1:0] d);
        drive(1'b1, 1'b0, a, '0, 2'b00);
        @(negedge clk);
        v = rd_vld;
        d = rd_data;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_rdy !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        logic v;
        logic [DATA_W-1:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_rdy !== 1'b0 || rd_vld !== 1'b0 || rd_data !== 16'h0 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b, required 0/0/0000/0", req_rdy, rd_vld, rd_data, err);
        end
        // write held during INIT must be ignored
        req_vld = 1'b1; we = 1'b1; addr = 10'd5; wrt_data = 16'hFFFF; byte_en = 2'b11;
        rst = 1'b0;
        wait_ready(n);
        req_vld = 1'b0; we = 1'b0;
        n_cmp++;
        if (n != DEPTH) begin
            n_mis++;
            $display("FAIL init_length: ready after %0d cycles, required %0d", n, DEPTH);
        end
        read_word(10'd0, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_mis++;
            $display("FAIL init_word0: vld=%b data=%h, required 1/0000", v, d);
        end
        read_word(10'd5, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_mis++;
            $display("FAIL init_word5: vld=%b data=%h, required 1/0000", v, d);
        end
        read_word(10'd999, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_mis++;
            $display("FAIL init_last_word: vld=%b data=%h, required 1/0000", v, d);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b0 || rd_data !== 16'h0 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_after_read: vld=%b data=%h err=%b, required 0/0000/0", rd_vld, rd_data, err);
        end
    endtask

    task automatic test_byte_en;
        logic v;
        logic [DATA_W-1:0] d;
        drive(1'b0, 1'b1, 10'd3, 16'hABCD, 2'b11);
        drive(1'b0, 1'b1, 10'd3, 16'h1234, 2'b01);
        read_word(10'd3, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'hAB34) begin
            n_mis++;
            $display("FAIL byte_en_low: vld=%b data=%h, required 1/ab34", v, d);
        end
        drive(1'b0, 1'b1, 10'd3, 16'h5678, 2'b10);
        drive(1'b0, 1'b1, 10'd3, 16'hFFFF, 2'b00);
        read_word(10'd3, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h5634) begin
            n_mis++;
            $display("FAIL byte_en_high_none: vld=%b data=%h, required 1/5634", v, d);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b0, 1'b1, 10'd1, 16'h0011, 2'b11);
        drive(1'b0, 1'b1, 10'd2, 16'h0022, 2'b11);
        drive(1'b0, 1'b1, 10'd3, 16'h0033, 2'b11);
        req_vld = 1'b1; re = 1'b1; addr = 10'd1;
        @(negedge clk);
        addr = 10'd2;
        n_cmp++;
        if (rd_vld !== 1'b0 || rd_data !== 16'h0) begin
            n_mis++;
            $display("FAIL b2b_latency: vld=%b data=%h one cycle after accept, required 0/0000", rd_vld, rd_data);
        end
        @(negedge clk);
        addr = 10'd3;
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 16'h0011) begin
            n_mis++;
            $display("FAIL b2b_first: vld=%b data=%h, required 1/0011", rd_vld, rd_data);
        end
        @(negedge clk);
        req_vld = 1'b0; re = 1'b0;
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 16'h0022) begin
            n_mis++;
            $display("FAIL b2b_second: vld=%b data=%h, required 1/0022", rd_vld, rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 16'h0033) begin
            n_mis++;
            $display("FAIL b2b_third: vld=%b data=%h, required 1/0033", rd_vld, rd_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b0 || rd_data !== 16'h0) begin
            n_mis++;
            $display("FAIL b2b_end: vld=%b data=%h, required 0/0000", rd_vld, rd_data);
        end
        // read accepted on the edge right after a write to the same word
        drive(1'b0, 1'b1, 10'd9, 16'hBEEF, 2'b11);
        drive(1'b1, 1'b0, 10'd9, '0, 2'b00);
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b1 || rd_data !== 16'hBEEF) begin
            n_mis++;
            $display("FAIL write_then_read: vld=%b data=%h, required 1/beef", rd_vld, rd_data);
        end
    endtask

    task automatic test_both_and_noop;
        logic v;
        logic [DATA_W-1:0] d;
        logic seen;
        drive(1'b0, 1'b1, 10'd4, 16'h4444, 2'b11);
        drive(1'b0, 1'b0, 10'd4, 16'hFFFF, 2'b11);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_vld !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || err !== 1'b0) begin
            n_mis++;
            $display("FAIL noop: rd_vld_seen=%b err=%b, required 0/0", seen, err);
        end
        drive(1'b1, 1'b1, 10'd4, 16'hFFFF, 2'b11);
        seen = 1'b0;
        repeat (4) begin
            if (rd_vld !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b0 || err !== 1'b1) begin
            n_mis++;
            $display("FAIL both_re_we: rd_vld_seen=%b err=%b, required 0/1", seen, err);
        end
        read_word(10'd4, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h4444) begin
            n_mis++;
            $display("FAIL both_mem_kept: vld=%b data=%h, required 1/4444", v, d);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_mis++;
            $display("FAIL err_clear: err=%b, required 0", err);
        end
        // set and clear in the same cycle: set wins
        err_clr = 1'b1;
        drive(1'b1, 1'b1, 10'd4, 16'h0, 2'b00);
        err_clr = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin
            n_mis++;
            $display("FAIL err_set_wins: err=%b, required 1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_out_of_range;
        logic v;
        logic [DATA_W-1:0] d;
        drive(1'b0, 1'b1, 10'd999, 16'h9999, 2'b11);
        n_cmp++;
        if (err !== 1'b0) begin
            n_mis++;
            $display("FAIL last_word_write_err: err=%b, required 0", err);
        end
        drive(1'b0, 1'b1, 10'd1020, 16'hDEAD, 2'b11);
        n_cmp++;
        if (err !== 1'b1) begin
            n_mis++;
            $display("FAIL oob_write_err: err=%b, required 1", err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        read_word(10'd1020, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000 || err !== 1'b1) begin
            n_mis++;
            $display("FAIL oob_read: vld=%b data=%h err=%b, required 1/0000/1", v, d, err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        read_word(10'd1000, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000 || err !== 1'b1) begin
            n_mis++;
            $display("FAIL oob_read_depth: vld=%b data=%h err=%b, required 1/0000/1", v, d, err);
        end
        read_word(10'd999, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h9999) begin
            n_mis++;
            $display("FAIL oob_mem_kept: vld=%b data=%h, required 1/9999", v, d);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int n;
        logic v;
        logic [DATA_W-1:0] d;
        drive(1'b0, 1'b1, 10'd7, 16'h5555, 2'b11);
        drive(1'b1, 1'b1, 10'd7, 16'h0, 2'b00);
        req_vld = 1'b1; re = 1'b1; addr = 10'd7;
        @(negedge clk);
        req_vld = 1'b0; re = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b0 || req_rdy !== 1'b0 || err !== 1'b0 || rd_data !== 16'h0) begin
            n_mis++;
            $display("FAIL mid_reset_outputs: vld=%b rdy=%b err=%b data=%h, required 0/0/0/0000", rd_vld, req_rdy, err, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rd_vld !== 1'b0) begin
            n_mis++;
            $display("FAIL mid_reset_discard: vld=%b, required 0", rd_vld);
        end
        wait_ready(n);
        n_cmp++;
        if (n != DEPTH - 1) begin
            n_mis++;
            $display("FAIL mid_reset_init_length: ready after %0d more cycles, required %0d", n, DEPTH - 1);
        end
        read_word(10'd7, v, d);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_mis++;
            $display("FAIL mid_reset_cleared: vld=%b data=%h, required 1/0000", v, d);
        end
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; re = 1'b0; we = 1'b0;
        addr = '0; wrt_data = '0; byte_en = '0; err_clr = 1'b0;
        test_reset();
        test_byte_en();
        test_back_to_back();
        test_both_and_noop();
        test_out_of_range();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
